// File: rtl/irq_priority_ctrl_if.sv
// Request/mask/handshake bundle between the CPU-side sequencer (master) and the
// priority interrupt controller (slave).
interface irq_priority_ctrl_if;
    logic [7:0] ReqIn_n;
    logic       EI;
    logic [7:0] MaskIn;
    logic       MaskWr;
    logic       Ack;
    logic       Eoi;
    logic       Irq;
    logic [2:0] Vector;
    logic       Busy;
    logic [7:0] Pending;
    logic       GS;
    logic       EO;

    modport master (
        output ReqIn_n, EI, MaskIn, MaskWr, Ack, Eoi,
        input  Irq, Vector, Busy, Pending, GS, EO
    );

    modport slave (
        input  ReqIn_n, EI, MaskIn, MaskWr, Ack, Eoi,
        output Irq, Vector, Busy, Pending, GS, EO
    );
endinterface

// File: rtl/irq_priority_ctrl.sv
// 8-line interrupt controller using the 74HC148 priority rule (line 7 highest),
// with pending/mask registers and a single-level Irq/Ack/Eoi handshake.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | no request raised; waits for EI=0 and an unmasked pending line
//   REQ     | Irq high, Vector tracks the current winner until Ack
//   SERVICE | Busy high, Vector frozen until Eoi
module irq_priority_ctrl #(
    parameter bit         EDGE_MODE = 1'b1,
    parameter logic [7:0] MASK_RST  = 8'h00
) (
    input logic                CLK,
    input logic                RST,
    irq_priority_ctrl_if.slave bus
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] REQ     = 2'd1;
    localparam logic [1:0] SERVICE = 2'd2;

    logic [1:0] state;
    logic [7:0] reqQ;
    logic [7:0] reqPrev;
    logic [7:0] pending;
    logic [7:0] mask;
    logic [2:0] vector;

    logic [7:0] reqEdge;
    logic [7:0] cand;
    logic [7:0] ackClr;
    logic [7:0] pendingNext;
    logic [2:0] winner;
    logic       ackTake;

    assign reqEdge = reqQ & ~reqPrev;
    assign cand    = pending & ~mask;
    assign ackTake = (state == REQ) && bus.Ack;
    assign ackClr  = ackTake ? (8'd1 << vector) : 8'd0;

    // A fresh edge on the line being acknowledged survives the clear.
    assign pendingNext = EDGE_MODE ? ((pending & ~ackClr) | reqEdge) : reqQ;

    always_comb begin
        winner = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (cand[i]) winner = 3'(i);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            reqQ    <= 8'd0;
            reqPrev <= 8'd0;
            pending <= 8'd0;
            mask    <= MASK_RST;
        end else begin
            reqQ    <= ~bus.ReqIn_n;
            reqPrev <= reqQ;
            pending <= pendingNext;
            if (bus.MaskWr) mask <= bus.MaskIn;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            vector <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (!bus.EI && (cand != 8'd0)) begin
                        state  <= REQ;
                        vector <= winner;
                    end
                end
                REQ: begin
                    if (ackTake) begin
                        state <= SERVICE;
                    end else if (bus.EI || (cand == 8'd0)) begin
                        state <= IDLE;
                    end else begin
                        vector <= winner;
                    end
                end
                SERVICE: begin
                    if (bus.Eoi) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.Irq     = (state == REQ);
    assign bus.Busy    = (state == SERVICE);
    assign bus.Vector  = vector;
    assign bus.Pending = pending;
    assign bus.GS      = ~(~bus.EI & (|cand));
    assign bus.EO      = ~(~bus.EI & ~(|cand));
endmodule

// File: tb/tb_irq_priority_ctrl.sv
// Edge-mode and level-mode controllers driven by the same stimulus; a per-cycle
// reference model feeds a scoreboard queue that a negedge monitor drains.
module tb_irq_priority_ctrl;
    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    irq_priority_ctrl_if busE();
    irq_priority_ctrl_if busL();

    irq_priority_ctrl #(.EDGE_MODE(1'b1), .MASK_RST(8'h00)) dutEdge (
        .CLK(CLK), .RST(RST), .bus(busE));
    irq_priority_ctrl #(.EDGE_MODE(1'b0), .MASK_RST(8'h00)) dutLevel (
        .CLK(CLK), .RST(RST), .bus(busL));

    typedef struct packed {
        logic       rst;
        logic [7:0] reqIn;
        logic       ei;
        logic [7:0] maskIn;
        logic       maskWr;
        logic       ack;
        logic       eoi;
    } stim_t;

    // phase: 0 = idle, 1 = requesting CPU, 2 = being serviced
    typedef struct {
        logic [7:0] reqQ;
        logic [7:0] reqPrev;
        logic [7:0] pend;
        logic [7:0] msk;
        logic [2:0] vec;
        int         phase;
    } model_t;

    typedef struct {
        logic       irq;
        logic       busy;
        logic       gs;
        logic       eo;
        logic [2:0] vec;
        logic [7:0] pend;
    } exp_t;

    typedef struct {
        exp_t e;
        exp_t l;
    } pair_t;

    stim_t  cur;
    model_t mE;
    model_t mL;
    bit     modelValid = 1'b0;
    pair_t  scoreQ[$];
    int     checks = 0;
    int     errors = 0;

    function automatic int topIndex(logic [7:0] v);
        int r = -1;
        for (int i = 0; i < 8; i++) if (v[i]) r = i;
        return r;
    endfunction

    function automatic model_t modelStep(model_t m, bit edgeMode, stim_t s);
        model_t     n;
        logic [7:0] rose;
        int         win;
        n = m;
        if (s.rst) begin
            n.reqQ = 8'd0; n.reqPrev = 8'd0; n.pend = 8'd0;
            n.msk = 8'h00; n.vec = 3'd0; n.phase = 0;
            return n;
        end
        win       = topIndex(m.pend & ~m.msk);
        rose      = m.reqQ & ~m.reqPrev;
        n.reqQ    = ~s.reqIn;
        n.reqPrev = m.reqQ;
        if (edgeMode) begin
            for (int i = 0; i < 8; i++)
                n.pend[i] = rose[i] | (m.pend[i] & !(m.phase == 1 && s.ack && int'(m.vec) == i));
        end else begin
            n.pend = m.reqQ;
        end
        if (s.maskWr) n.msk = s.maskIn;
        case (m.phase)
            0: if (!s.ei && win >= 0) begin n.phase = 1; n.vec = 3'(win); end
            1: begin
                if (s.ack) n.phase = 2;
                else if (s.ei || win < 0) n.phase = 0;
                else n.vec = 3'(win);
            end
            2: if (s.eoi) n.phase = 0;
            default: n.phase = 0;
        endcase
        return n;
    endfunction

    function automatic exp_t predictOut(model_t m, logic ei);
        exp_t e;
        logic any;
        any    = |(m.pend & ~m.msk);
        e.irq  = (m.phase == 1);
        e.busy = (m.phase == 2);
        e.vec  = m.vec;
        e.pend = m.pend;
        e.gs   = !(!ei && any);
        e.eo   = !(!ei && !any);
        return e;
    endfunction

    task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic compareOut(string tag, exp_t e, logic irq, logic busy, logic gs,
                              logic eo, logic [2:0] vec, logic [7:0] pend);
        chk({tag, ".Irq"}, 8'(irq), 8'(e.irq));
        chk({tag, ".Busy"}, 8'(busy), 8'(e.busy));
        chk({tag, ".GS"}, 8'(gs), 8'(e.gs));
        chk({tag, ".EO"}, 8'(eo), 8'(e.eo));
        chk({tag, ".Vector"}, 8'(vec), 8'(e.vec));
        chk({tag, ".Pending"}, pend, e.pend);
    endtask

    always @(negedge CLK) begin
        pair_t p;
        if (scoreQ.size() > 0) begin
            p = scoreQ.pop_front();
            compareOut("edge", p.e, busE.Irq, busE.Busy, busE.GS, busE.EO, busE.Vector, busE.Pending);
            compareOut("level", p.l, busL.Irq, busL.Busy, busL.GS, busL.EO, busL.Vector, busL.Pending);
        end
    end

    task automatic tick();
        pair_t p;
        RST = cur.rst;
        busE.ReqIn_n = cur.reqIn; busE.EI = cur.ei; busE.MaskIn = cur.maskIn;
        busE.MaskWr = cur.maskWr; busE.Ack = cur.ack; busE.Eoi = cur.eoi;
        busL.ReqIn_n = cur.reqIn; busL.EI = cur.ei; busL.MaskIn = cur.maskIn;
        busL.MaskWr = cur.maskWr; busL.Ack = cur.ack; busL.Eoi = cur.eoi;
        if (modelValid) begin
            p.e = predictOut(mE, cur.ei);
            p.l = predictOut(mL, cur.ei);
            scoreQ.push_back(p);
        end
        @(posedge CLK);
        mE = modelStep(mE, 1'b1, cur);
        mL = modelStep(mL, 1'b0, cur);
        if (cur.rst) modelValid = 1'b1;
        #1;
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulseAck();
        cur.ack = 1'b1; tick(); cur.ack = 1'b0;
    endtask

    task automatic pulseEoi();
        cur.eoi = 1'b1; tick(); cur.eoi = 1'b0;
    endtask

    task automatic doReset();
        cur = '{rst: 1'b1, reqIn: 8'hFF, ei: 1'b0, maskIn: 8'h00, maskWr: 1'b0, ack: 1'b0, eoi: 1'b0};
        tick();
        cur.rst = 1'b0;
    endtask

    initial begin
        doReset();
        chk("reset.Irq", 8'(busE.Irq), 8'd0);
        chk("reset.EO", 8'(busE.EO), 8'd0);

        // single edge on line 2
        cur.reqIn = 8'hFB; ticks(3);
        chk("t1.Irq", 8'(busE.Irq), 8'd1);
        chk("t1.Vector", 8'(busE.Vector), 8'd2);
        chk("t1.GS", 8'(busE.GS), 8'd0);
        pulseAck();
        chk("t1.Busy", 8'(busE.Busy), 8'd1);
        chk("t1.Pending", busE.Pending, 8'h00);
        pulseEoi();
        chk("t1.EO", 8'(busE.EO), 8'd0);

        // priority among simultaneous lines 1,5,6
        doReset(); cur.reqIn = 8'h9D; ticks(3);
        chk("t2.v6", 8'(busE.Vector), 8'd6);
        pulseAck(); pulseEoi(); tick();
        chk("t2.v5", 8'(busE.Vector), 8'd5);
        pulseAck(); pulseEoi(); tick();
        chk("t2.v1", 8'(busE.Vector), 8'd1);

        // pre-emption before Ack
        doReset(); cur.reqIn = 8'hF7; ticks(3);
        chk("t3.v3", 8'(busE.Vector), 8'd3);
        cur.reqIn = 8'h77; ticks(3);
        chk("t3.v7", 8'(busE.Vector), 8'd7);
        pulseAck();
        chk("t3.Pending", busE.Pending, 8'h08);
        pulseEoi();

        // mask and enable
        doReset(); cur.maskIn = 8'h80; cur.maskWr = 1'b1; cur.reqIn = 8'h7F; tick();
        cur.maskWr = 1'b0; ticks(3);
        chk("t4.Irq", 8'(busE.Irq), 8'd0);
        chk("t4.Pending", busE.Pending, 8'h80);
        chk("t4.EO", 8'(busE.EO), 8'd0);
        cur.maskIn = 8'h00; cur.maskWr = 1'b1; tick(); cur.maskWr = 1'b0; tick();
        chk("t4.unmask.Irq", 8'(busE.Irq), 8'd1);
        chk("t4.unmask.Vector", 8'(busE.Vector), 8'd7);
        cur.ei = 1'b1; tick();
        chk("t4.ei.Irq", 8'(busE.Irq), 8'd0);
        chk("t4.ei.GS", 8'(busE.GS), 8'd1);
        chk("t4.ei.EO", 8'(busE.EO), 8'd1);
        cur.ei = 1'b0;

        // Ack+Eoi collision, then re-edge on the Ack cycle
        doReset(); cur.reqIn = 8'hFE; ticks(3);
        cur.ack = 1'b1; cur.eoi = 1'b1; tick(); cur.ack = 1'b0; cur.eoi = 1'b0;
        chk("t5.Busy", 8'(busE.Busy), 8'd1);
        pulseEoi();
        cur.reqIn = 8'hEF; ticks(3);
        chk("t5.v4", 8'(busE.Vector), 8'd4);
        cur.reqIn = 8'hFF; tick();
        cur.reqIn = 8'hEF; tick();
        pulseAck();
        pulseEoi();
        chk("t5.Pending4", 8'(busE.Pending[4]), 8'd1);

        // reset during service, then level-mode re-request
        doReset(); cur.reqIn = 8'hFB; ticks(3); pulseAck();
        chk("t6.Busy", 8'(busE.Busy), 8'd1);
        cur.rst = 1'b1; tick(); cur.rst = 1'b0;
        chk("t6.Irq", 8'(busE.Irq), 8'd0);
        chk("t6.Busy0", 8'(busE.Busy), 8'd0);
        chk("t6.Pending", busE.Pending, 8'h00);
        chk("t6.Vector", 8'(busE.Vector), 8'd0);
        ticks(3); pulseAck(); pulseEoi(); tick();
        chk("t6.level.Irq", 8'(busL.Irq), 8'd1);
        chk("t6.edge.Irq", 8'(busE.Irq), 8'd0);

        // randomized traffic
        doReset();
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 8; b++)
                if ($urandom_range(7) == 0) cur.reqIn[b] = ~cur.reqIn[b];
            cur.ack    = ($urandom_range(3) == 0);
            cur.eoi    = ($urandom_range(4) == 0);
            cur.maskWr = ($urandom_range(15) == 0);
            cur.maskIn = 8'($urandom_range(255) & $urandom_range(255));
            if (cur.ei ? ($urandom_range(3) == 0) : ($urandom_range(39) == 0)) cur.ei = ~cur.ei;
            cur.rst    = ($urandom_range(299) == 0);
            tick();
        end
        cur = '{rst: 1'b0, reqIn: 8'hFF, ei: 1'b0, maskIn: 8'h00, maskWr: 1'b0, ack: 1'b0, eoi: 1'b0};
        tick();
        @(negedge CLK); #1;
        chk("scoreboard.drain", 8'(scoreQ.size()), 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
